regfile_wb_arbiter: RTL and testbench

//  Write-side front end for the 32x32 register file: collects results from two producers (ALU and load

---
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Buffers ALU and load results in per-source FIFOs and serializes
//            them onto the register file write port; publishes pending mask.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic [4:0]  wb_a3,
    output logic [31:0] wb_wd3,
    output logic        wb_we3,
    output logic [31:0] pend_mask
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              WW         = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0]     FULL       = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0]   WAIT_LIMIT = WW'(MAX_WAIT);

    logic          alu_win;
    logic          ld_win;
    logic          force_alu;
    logic [WW-1:0] wait_cnt;

    // Index 0 is the ALU FIFO, index 1 is the load FIFO.
    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic          in_valid;
        logic [4:0]    in_rd;
        logic [31:0]   in_data;
        logic          pop;
        logic          push;
        logic          ready;
        logic          nonempty;
        logic [4:0]    head_rd;
        logic [31:0]   head_data;
        logic [4:0]    rd_mem   [DEPTH];
        logic [31:0]   data_mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW-1:0] offs;
        logic [AW:0]   count;
        logic [31:0]   mask;

        assign in_valid  = (s == 0) ? alu_valid : ld_valid;
        assign in_rd     = (s == 0) ? alu_rd    : ld_rd;
        assign in_data   = (s == 0) ? alu_data  : ld_data;
        assign pop       = (s == 0) ? alu_win   : ld_win;

        assign ready     = nrst && (count < FULL);
        // Writes to x0 complete the handshake but are dropped here.
        assign push      = in_valid && ready && (in_rd != 5'd0);
        assign nonempty  = (count != '0);
        assign head_rd   = rd_mem[rd_ptr];
        assign head_data = data_mem[rd_ptr];

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                rd_mem[wr_ptr]   <= in_rd;
                data_mem[wr_ptr] <= in_data;
            end
        end

        // An entry is live when its distance from the read pointer is below count.
        always_comb begin
            mask = '0;
            offs = '0;
            for (int i = 0; i < DEPTH; i++) begin
                offs = AW'(i) - rd_ptr;
                if ({1'b0, offs} < count) mask[rd_mem[AW'(i)]] = 1'b1;
            end
        end
    end

    assign alu_ready = g_fifo[0].ready;
    assign ld_ready  = g_fifo[1].ready;

    assign force_alu = (wait_cnt == WAIT_LIMIT);
    assign alu_win   = g_fifo[0].nonempty && (!g_fifo[1].nonempty || force_alu);
    assign ld_win    = g_fifo[1].nonempty && !(g_fifo[0].nonempty && force_alu);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt <= '0;
        end else if (g_fifo[0].nonempty && !alu_win) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wb_we3 <= 1'b0;
            wb_a3  <= '0;
            wb_wd3 <= '0;
        end else begin
            wb_we3 <= alu_win || ld_win;
            if (alu_win) begin
                wb_a3  <= g_fifo[0].head_rd;
                wb_wd3 <= g_fifo[0].head_data;
            end else if (ld_win) begin
                wb_a3  <= g_fifo[1].head_rd;
                wb_wd3 <= g_fifo[1].head_data;
            end
        end
    end

    always_comb begin
        pend_mask = g_fifo[0].mask | g_fifo[1].mask;
        if (wb_we3) pend_mask[wb_a3] = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Scoreboard bench for regfile_wb_arbiter write-back serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd3;
    logic        wb_we3;
    logic [31:0] pend_mask;

    logic [36:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .wb_a3     (wb_a3),
        .wb_wd3    (wb_wd3),
        .wb_we3    (wb_we3),
        .pend_mask (pend_mask)
    );

    // Every write on the port must match the oldest expected write.
    always @(negedge clk) begin : monitor
        logic [36:0] e;
        if (nrst && wb_we3) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_write: got a3=%0d wd3=%h, expected no write", wb_a3, wb_wd3);
            end else begin
                e = exp_q.pop_front();
                if ({wb_a3, wb_wd3} !== e) begin
                    n_fail++;
                    $display("FAIL wb_write: got a3=%0d wd3=%h, expected a3=%0d wd3=%h",
                             wb_a3, wb_wd3, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic idle;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || pend_mask != 32'd0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 60) begin
            n_fail++;
            $display("FAIL %s_drain: got queue=%0d pend=%h, expected empty", tag, exp_q.size(), pend_mask);
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_cmp++; if (wb_we3 !== 1'b0)     begin n_fail++; $display("FAIL rst_we3: got %b, expected 0", wb_we3); end
        n_cmp++; if (wb_a3 !== 5'd0)      begin n_fail++; $display("FAIL rst_a3: got %0d, expected 0", wb_a3); end
        n_cmp++; if (wb_wd3 !== 32'd0)    begin n_fail++; $display("FAIL rst_wd3: got %h, expected 0", wb_wd3); end
        n_cmp++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL rst_pend: got %h, expected 0", pend_mask); end
        n_cmp++; if (alu_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_alu_ready: got %b, expected 0", alu_ready); end
        n_cmp++; if (ld_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_ld_ready: got %b, expected 0", ld_ready); end
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_release_ready: got %b%b, expected 11", alu_ready, ld_ready);
        end
    endtask

    task automatic test_single;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        idle();
        n_cmp++; if (pend_mask !== 32'h20) begin n_fail++; $display("FAIL single_pend_accept: got %h, expected 00000020", pend_mask); end
        n_cmp++; if (wb_we3 !== 1'b0)      begin n_fail++; $display("FAIL single_we3_early: got %b, expected 0", wb_we3); end
        @(negedge clk);
        n_cmp++; if (wb_we3 !== 1'b1)      begin n_fail++; $display("FAIL single_we3: got %b, expected 1", wb_we3); end
        n_cmp++; if (pend_mask !== 32'h20) begin n_fail++; $display("FAIL single_pend_write: got %h, expected 00000020", pend_mask); end
        @(negedge clk);
        n_cmp++; if (wb_we3 !== 1'b0)      begin n_fail++; $display("FAIL single_we3_after: got %b, expected 0", wb_we3); end
        n_cmp++; if (pend_mask !== 32'h0)  begin n_fail++; $display("FAIL single_pend_after: got %h, expected 0", pend_mask); end
    endtask

    task automatic test_dual;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h22;
        exp_q.push_back({5'd4, 32'h22});
        exp_q.push_back({5'd3, 32'h11});
        @(negedge clk);
        idle();
        n_cmp++; if (pend_mask !== 32'h18) begin n_fail++; $display("FAIL dual_pend: got %h, expected 00000018", pend_mask); end
        @(negedge clk);
        n_cmp++; if (wb_we3 !== 1'b1 || wb_a3 !== 5'd4) begin n_fail++; $display("FAIL dual_first: got we=%b a3=%0d, expected we=1 a3=4", wb_we3, wb_a3); end
        @(negedge clk);
        n_cmp++; if (wb_we3 !== 1'b1 || wb_a3 !== 5'd3) begin n_fail++; $display("FAIL dual_second: got we=%b a3=%0d, expected we=1 a3=3", wb_we3, wb_a3); end
    endtask

    task automatic test_starvation;
        int wr_no  = 0;
        int alu_at = 0;
        for (int c = 0; c < 3; c++) exp_q.push_back({5'(8 + c), 32'h1D00_0000 + 32'(c)});
        exp_q.push_back({5'd7, 32'hA7A7_0007});
        for (int c = 3; c < 6; c++) exp_q.push_back({5'(8 + c), 32'h1D00_0000 + 32'(c)});
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA7A7_0007;
        for (int c = 0; c < 12; c++) begin
            ld_valid = (c < 6); ld_rd = 5'(8 + c); ld_data = 32'h1D00_0000 + 32'(c);
            @(negedge clk);
            alu_valid = 1'b0;
            if (wb_we3) begin
                wr_no++;
                if (wb_a3 == 5'd7) alu_at = wr_no;
            end
        end
        idle();
        n_cmp++; if (alu_at != 4) begin n_fail++; $display("FAIL starve_alu_slot: got write #%0d, expected #4", alu_at); end
    endtask

    task automatic test_fill_wrap;
        int ai = 0;
        bit acc;
        for (int c = 1; c <= 3; c++) exp_q.push_back({5'(27 + c), 32'h1D00_0100 + 32'(c)});
        exp_q.push_back({5'd16, 32'hA000_0000});
        exp_q.push_back({5'd31, 32'h1D00_0104});
        for (int a = 1; a < 10; a++) exp_q.push_back({5'(16 + a), 32'hA000_0000 + 32'(a)});
        for (int c = 1; c <= 30; c++) begin
            alu_valid = (ai < 10); alu_rd = 5'(16 + ai); alu_data = 32'hA000_0000 + 32'(ai);
            ld_valid  = (c <= 4);  ld_rd  = 5'(27 + c);  ld_data  = 32'h1D00_0100 + 32'(c);
            acc = alu_valid && alu_ready;
            @(negedge clk);
            if (acc) ai++;
            if (c == 4) begin
                n_cmp++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b, expected 0", alu_ready); end
                n_cmp++; if (pend_mask !== 32'hC00F_0000) begin n_fail++; $display("FAIL fill_pend: got %h, expected c00f0000", pend_mask); end
            end
            if (c == 5) begin
                n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL fill_drain_ready: got %b, expected 1", alu_ready); end
            end
        end
        idle();
        n_cmp++; if (ai != 10) begin n_fail++; $display("FAIL fill_accepts: got %0d, expected 10", ai); end
    endtask

    task automatic test_rd_zero;
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %b, expected 1", alu_ready); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        idle();
        repeat (3) begin
            n_cmp++; if (wb_we3 !== 1'b0)     begin n_fail++; $display("FAIL rd0_we3: got %b, expected 0", wb_we3); end
            n_cmp++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL rd0_pend: got %h, expected 0", pend_mask); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'hB2;
        exp_q.push_back({5'd2, 32'hB2});
        @(negedge clk);
        alu_rd = 5'd3; alu_data = 32'hA3;
        ld_rd  = 5'd4; ld_data  = 32'hB4;
        @(negedge clk);
        idle();
        n_cmp++; if (wb_we3 !== 1'b1)      begin n_fail++; $display("FAIL arst_pre_we3: got %b, expected 1", wb_we3); end
        n_cmp++; if (pend_mask !== 32'h1E) begin n_fail++; $display("FAIL arst_pre_pend: got %h, expected 0000001e", pend_mask); end
        #1 nrst = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++; if (wb_we3 !== 1'b0 || wb_a3 !== 5'd0 || wb_wd3 !== 32'd0) begin
            n_fail++; $display("FAIL arst_port: got we=%b a3=%0d wd3=%h, expected 0/0/0", wb_we3, wb_a3, wb_wd3);
        end
        n_cmp++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL arst_pend: got %h, expected 0", pend_mask); end
        n_cmp++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL arst_ready: got %b%b, expected 00", alu_ready, ld_ready);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL arst_release_ready: got %b%b, expected 11", alu_ready, ld_ready);
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if (wb_we3 !== 1'b0) begin n_fail++; $display("FAIL arst_stale_write: got we=1 a3=%0d, expected no write", wb_a3); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        wait_drain("single");
        test_dual();
        wait_drain("dual");
        test_starvation();
        wait_drain("starve");
        test_fill_wrap();
        wait_drain("fill");
        test_rd_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
